// File: rtl/tag_spawn_picker.sv
// Spawn-position picker for the VGA tag game: assembles (x, y) from LFSR samples, retries out-of-bounds picks, falls back after MAX_TRIES.
// Optional macro SPAWN_AVOID_EN also rejects candidates within AVOID_DIST of the player.
module tag_spawn_picker #(
    parameter int LFSR_BITS  = 3,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 10,
    parameter int X_MAX      = 620,
    parameter int Y_MAX      = 460,
    parameter int MAX_TRIES  = 8,
    parameter int FALLBACK_X = 320,
    parameter int FALLBACK_Y = 240,
    parameter int AVOID_DIST = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spawn_req,
    output logic                 lfsr_en,
    input  logic [LFSR_BITS-1:0] lfsr_out,
    input  logic [X_BITS-1:0]    player_x,
    input  logic [Y_BITS-1:0]    player_y,
    output logic [X_BITS-1:0]    spawn_x,
    output logic [Y_BITS-1:0]    spawn_y,
    output logic                 spawn_valid,
    input  logic                 spawn_ready,
    output logic                 spawn_fallback,
    output logic                 busy
);
    localparam int NX   = (X_BITS + LFSR_BITS - 1) / LFSR_BITS;
    localparam int NY   = (Y_BITS + LFSR_BITS - 1) / LFSR_BITS;
    localparam int NS   = NX + NY;
    localparam int SH_W = NS * LFSR_BITS;
    localparam int CW   = $clog2(NS + 1);
    localparam int TW   = $clog2(MAX_TRIES + 1);

    localparam logic [X_BITS-1:0] XMAX_C = X_BITS'(X_MAX);
    localparam logic [Y_BITS-1:0] YMAX_C = Y_BITS'(Y_MAX);
    localparam logic [X_BITS-1:0] FBX_C  = X_BITS'(FALLBACK_X);
    localparam logic [Y_BITS-1:0] FBY_C  = Y_BITS'(FALLBACK_Y);
    localparam logic [CW-1:0]     LAST_S = CW'(NS - 1);
    localparam logic [TW-1:0]     LAST_T = TW'(MAX_TRIES - 1);

    typedef enum logic [2:0] {IDLE, PULSE, CAPTURE, CHECK, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       samp_q, samp_d;
    logic [TW-1:0]       tries_q, tries_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic [X_BITS-1:0]   x_q, x_d;
    logic [Y_BITS-1:0]   y_q, y_d;
    logic                fb_q, fb_d;

    logic [X_BITS-1:0]   cand_x;
    logic [Y_BITS-1:0]   cand_y;
    logic                in_bounds, accept;

    // The register holds every sample, so x is the earliest NX samples and y the latest NY, each truncated to width.
    assign cand_x = shift_q[NY*LFSR_BITS +: X_BITS];
    assign cand_y = shift_q[0 +: Y_BITS];

`ifdef SPAWN_AVOID_EN
    localparam logic [X_BITS:0] AVX_C = (X_BITS+1)'(AVOID_DIST);
    localparam logic [Y_BITS:0] AVY_C = (Y_BITS+1)'(AVOID_DIST);
    logic [X_BITS:0] dx;
    logic [Y_BITS:0] dy;

    always_comb begin
        dx = {1'b0, cand_x} - {1'b0, player_x};
        dy = {1'b0, cand_y} - {1'b0, player_y};
        if (dx[X_BITS]) dx = -dx;
        if (dy[Y_BITS]) dy = -dy;
        in_bounds = (cand_x <= XMAX_C) && (cand_y <= YMAX_C);
        accept    = in_bounds && !((dx < AVX_C) && (dy < AVY_C));
    end
`else
    logic unused_player;
    assign unused_player = ^{player_x, player_y};

    always_comb begin
        in_bounds = (cand_x <= XMAX_C) && (cand_y <= YMAX_C);
        accept    = in_bounds;
    end
`endif

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        tries_d = tries_q;
        shift_d = shift_q;
        x_d     = x_q;
        y_d     = y_q;
        fb_d    = fb_q;
        lfsr_en = 1'b0;
        unique case (state_q)
            IDLE: if (spawn_req) begin
                state_d = PULSE;
                samp_d  = '0;
                tries_d = '0;
                shift_d = '0;
            end
            PULSE: begin
                lfsr_en = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                shift_d = {shift_q[SH_W-LFSR_BITS-1:0], lfsr_out};
                samp_d  = samp_q + CW'(1);
                state_d = (samp_q == LAST_S) ? CHECK : PULSE;
            end
            CHECK: begin
                if (accept) begin
                    state_d = DONE;
                    x_d     = cand_x;
                    y_d     = cand_y;
                    fb_d    = 1'b0;
                end else if (tries_q == LAST_T) begin
                    state_d = DONE;
                    x_d     = FBX_C;
                    y_d     = FBY_C;
                    fb_d    = 1'b1;
                end else begin
                    // A rejected check is also the first pulse of the retry, so every attempt costs exactly 2*NS cycles.
                    lfsr_en = 1'b1;
                    tries_d = tries_q + TW'(1);
                    samp_d  = '0;
                    state_d = CAPTURE;
                end
            end
            DONE: if (spawn_ready) begin
                state_d = IDLE;
                fb_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            samp_q  <= '0;
            tries_q <= '0;
            shift_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            tries_q <= tries_d;
            shift_q <= shift_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fb_q    <= fb_d;
        end
    end

    assign spawn_x        = x_q;
    assign spawn_y        = y_q;
    assign spawn_fallback = fb_q;
    assign spawn_valid    = (state_q == DONE);
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_tag_spawn_picker.sv
// Directed bench for tag_spawn_picker: a pulse-counting LFSR stub, a per-request outcome model and a per-cycle output checker.
module tb_tag_spawn_picker;
    logic       clk = 1'b0;
    logic       reset, spawn_req, spawn_ready;
    logic       lfsr_en, spawn_valid, spawn_fallback, busy;
    logic [2:0] lfsr_out;
    logic [9:0] player_x, player_y, spawn_x, spawn_y;

    always #5 clk = ~clk;

    tag_spawn_picker dut (
        .clk(clk), .reset(reset), .spawn_req(spawn_req), .lfsr_en(lfsr_en),
        .lfsr_out(lfsr_out), .player_x(player_x), .player_y(player_y),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready), .spawn_fallback(spawn_fallback), .busy(busy)
    );

    // Stub LFSR: output word k is shown after the k-th enable pulse.
    logic [2:0]  pat [32];
    int unsigned pcnt = 0;
    int          cyc  = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lfsr_en === 1'b1) pcnt <= pcnt + 1;
    end
    assign lfsr_out = pat[pcnt[4:0]];

    // Per-request expectations (written by the stimulus process).
    int req_cyc = -1, m_v = 0, m_x = 0, m_y = 0, m_fb = 0;
    int lit_lat = 0, lit_x = 0, lit_y = 0, lit_fb = 0;
    // Checker-owned state.
    int end_cyc = -1, first_v = -1, hold_x = 0, hold_y = 0;
    int nvec = 0, nfail = 0;

    localparam int S_ORDER[16] = '{7,7,7,7, 0,0,0,0, 1,1,0,2, 4,7,0,5};
    localparam int S_EDGE[24]  = '{1,1,5,5, 0,7,1,4, 1,1,5,4, 0,7,1,5, 1,1,5,4, 0,7,1,4};

    // Outcome of a request from the spec rules: NX+NY=8 samples per try, first 4 -> x, next 4 -> y.
    function automatic void predict(input int p0, output int n, output int x, output int y, output int fb);
        n = 8; x = 320; y = 240; fb = 1;
        for (int t = 0; t < 8; t++) begin
            int cx, cy;
            bit ok;
            cx = 0; cy = 0;
            for (int j = 0; j < 4; j++) cx = cx * 8 + int'(pat[(p0 + 8*t + 1 + j) % 32]);
            for (int j = 4; j < 8; j++) cy = cy * 8 + int'(pat[(p0 + 8*t + 1 + j) % 32]);
            cx = cx % 1024;
            cy = cy % 1024;
            ok = (cx <= 620) && (cy <= 460);
`ifdef SPAWN_AVOID_EN
            if ((cx - int'(player_x) < 64) && (int'(player_x) - cx < 64) &&
                (cy - int'(player_y) < 64) && (int'(player_y) - cy < 64)) ok = 1'b0;
`endif
            if (ok) begin
                n = t + 1; x = cx; y = cy; fb = 0;
                return;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, a, e);
        end
    endtask

    // Every cycle: busy, lfsr_en schedule, valid window and held outputs against the model.
    always @(negedge clk) begin
        bit act, ev, een;
        if (reset === 1'b1) begin
            if (req_cyc >= 0 && cyc > req_cyc && end_cyc < req_cyc) end_cyc = cyc;
            hold_x = 0;
            hold_y = 0;
        end else begin
            act = (req_cyc >= 0) && (cyc > req_cyc) && (end_cyc < req_cyc);
            ev  = act && (cyc >= m_v);
            een = act && (cyc <= m_v - 3) && ((cyc - req_cyc - 1) % 2 == 0);
            chk("busy", busy, act);
            chk("lfsr_en", lfsr_en, een);
            chk("spawn_valid", spawn_valid, ev);
            chk("spawn_x", spawn_x, ev ? m_x : hold_x);
            chk("spawn_y", spawn_y, ev ? m_y : hold_y);
            chk("spawn_fallback", spawn_fallback, ev ? m_fb : 0);
            if (act && spawn_valid === 1'b1 && first_v < req_cyc) first_v = cyc;
            if (ev) begin
                hold_x = m_x;
                hold_y = m_y;
            end
            if (ev && spawn_ready === 1'b1) begin
                end_cyc = cyc;
                chk("latency", first_v - req_cyc, lit_lat);
                chk("lit_x", spawn_x, lit_x);
                chk("lit_y", spawn_y, lit_y);
                chk("lit_fallback", spawn_fallback, lit_fb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 32; i++) pat[i] = v[2:0];
    endtask

    // Place want-sample j where the j-th pulse after the next request will expose it.
    task automatic put(input int j, input int v);
        pat[(pcnt + 1 + j) % 32] = v[2:0];
    endtask

    task automatic start_req(input bit pre_rdy);
        int n;
        step();
        predict(int'(pcnt), n, m_x, m_y, m_fb);
        m_v         = cyc + 16*n + 2;
        req_cyc     = cyc;
        spawn_req   = 1'b1;
        spawn_ready = pre_rdy;
        step();
        spawn_req   = 1'b0;
    endtask

    task automatic run_txn(input int wait_k, input bit pre_rdy, input bit stray,
                           input int llat, input int lx, input int ly, input int lfb);
        lit_lat = llat; lit_x = lx; lit_y = ly; lit_fb = lfb;
        start_req(pre_rdy);
        if (stray) begin
            repeat (4) step();
            spawn_req = 1'b1;
            step();
            spawn_req = 1'b0;
            while (cyc < m_v + 1) step();
            spawn_req = 1'b1;
            step();
            spawn_req = 1'b0;
        end
        while (cyc < m_v + wait_k) step();
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; spawn_req = 1'b0; spawn_ready = 1'b0;
        player_x = '0; player_y = '0;
        fill(0);
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // All-zero samples: (0,0) first try, or fallback when avoidance is built in.
        fill(0);
`ifdef SPAWN_AVOID_EN
        run_txn(0, 1'b0, 1'b0, 130, 320, 240, 1);
`else
        run_txn(0, 1'b0, 1'b0, 18, 0, 0, 0);
`endif
        // Constant 3'b001: x=585, y=585 always out of range -> fallback, ready held off 5 cycles.
        fill(1);
        run_txn(5, 1'b0, 1'b0, 130, 320, 240, 1);

        // Sample order and truncation: try 1 x=1023 rejected, try 2 accepted; ready high before DONE.
        fill(0);
        for (int j = 0; j < 16; j++) put(j, S_ORDER[j]);
        run_txn(0, 1'b1, 1'b0, 34, 578, 453, 0);

        // Reset during the third CAPTURE aborts without a result.
        fill(0);
        lit_lat = 0; lit_x = 0; lit_y = 0; lit_fb = 0;
        start_req(1'b0);
        while (cyc < req_cyc + 6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();
`ifdef SPAWN_AVOID_EN
        run_txn(2, 1'b0, 1'b0, 130, 320, 240, 1);
`else
        run_txn(2, 1'b0, 1'b0, 18, 0, 0, 0);
`endif
        // Bounds edges (621,460), (620,461), then (620,460) accepted; stray requests while busy.
        fill(0);
        for (int j = 0; j < 24; j++) put(j, S_EDGE[j]);
        run_txn(4, 1'b0, 1'b1, 50, 620, 460, 0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
